namuru_psend: RTL and testbench

//  Sender end of the toggle-handshake crossing used by the Namuru correlator; runs in the clks domain.

---
 rtl/namuru_psend_pkg.sv | 15 +
 rtl/namuru_psend_sync.sv | 29 ++
 rtl/namuru_psend.sv | 140 ++++++++++++++
 tb/tb_namuru_psend.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/namuru_psend_pkg.sv
// namuru_psend_pkg
//  Shared definitions for the Namuru toggle-handshake sender.
//  - ps_state_e          : sender FSM encoding (IDLE=0, WAIT=1)
//  - NAMURU_SYNC_STAGES  : default ack synchroniser depth, shared with the
//                          far-side synchroniser so both ends use the same depth
package namuru_psend_pkg;

    typedef enum logic {
        PS_IDLE = 1'b0,
        PS_WAIT = 1'b1
    } ps_state_e;

    localparam int NAMURU_SYNC_STAGES = 4;

endpackage

// File: rtl/namuru_psend_sync.sv
// namuru_psend_sync
//  SYNC_STAGES-deep flop chain that brings the asynchronous ack toggle into
//  the clks domain.
//  Ports:
//   clks   in  sole clock
//   rstn   in  asynchronous active-low clear of the chain
//   ack_i  in  asynchronous far-side echo
//   ack_s  out synchronised ack (last stage)
module namuru_psend_sync
    import namuru_psend_pkg::*;
#(
    parameter int SYNC_STAGES = NAMURU_SYNC_STAGES
) (
    input  logic clks,
    input  logic rstn,
    input  logic ack_i,
    output logic ack_s
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clks or negedge rstn) begin
        if (!rstn) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], ack_i};
    end

    assign ack_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/namuru_psend.sv
// namuru_psend
//  Sender end of the Namuru toggle-handshake crossing (clks domain).
//  Each accepted event flips req_o; the next event is held until the far
//  side echoes the toggle back on ack_i. Events arriving meanwhile are queued
//  in a saturating pending counter.
//  Optional feature: define NAMURU_PSEND_TIMEOUT_EN to abandon a handshake
//  after TIMEOUT_CYC cycles in WAIT (req_o resyncs to ack, tmo_o set).
//  Ports:
//   clks       in  clock
//   rstn       in  asynchronous active-low reset
//   evt_i      in  one-cycle event pulse
//   ack_i      in  asynchronous far-side echo of req_o
//   ovf_clr_i  in  clears ovf_o (and tmo_o when the timeout is built)
//   req_o      out request toggle
//   busy_o     out handshake in flight
//   pend_o     out queued, unsent events
//   ovf_o      out sticky: event dropped on full queue
//   tmo_o      out sticky: ack timeout (constant 0 without the macro)
module namuru_psend
    import namuru_psend_pkg::*;
#(
    parameter int SYNC_STAGES = NAMURU_SYNC_STAGES,
    parameter int PEND_W      = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clks,
    input  logic              rstn,
    input  logic              evt_i,
    input  logic              ack_i,
    input  logic              ovf_clr_i,
    output logic              req_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pend_o,
    output logic              ovf_o,
    output logic              tmo_o
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 8) begin : g_bad_sync
        $error("namuru_psend: SYNC_STAGES must be 2..8");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_tmo
        $error("namuru_psend: TIMEOUT_CYC must be at least 2");
    end

    ps_state_e         state_q, state_d;
    logic              ack_s;
    logic              req_q;
    logic [PEND_W-1:0] pend_q;
    logic              ovf_q;
    logic              launch;
    logic              tmo_hit;
    logic              drop;

    namuru_psend_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clks  (clks),
        .rstn  (rstn),
        .ack_i (ack_i),
        .ack_s (ack_s)
    );

    // State register
    always_ff @(posedge clks or negedge rstn) begin
        if (!rstn) state_q <= PS_IDLE;
        else       state_q <= state_d;
    end

    // Next state; launch marks the cycle an event leaves on req
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        unique case (state_q)
            PS_IDLE: if (evt_i || (|pend_q)) begin
                launch  = 1'b1;
                state_d = PS_WAIT;
            end
            PS_WAIT: if ((ack_s == req_q) || tmo_hit) state_d = PS_IDLE;
            default: state_d = PS_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy_o = (state_q == PS_WAIT);
    end

    // An event not taken by a launch this cycle must queue; full queue drops it
    assign drop = evt_i && !launch && (&pend_q);

    always_ff @(posedge clks or negedge rstn) begin
        if (!rstn) begin
            req_q  <= 1'b0;
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (launch)       req_q <= ~req_q;
            else if (tmo_hit) req_q <= ack_s;   // resync so the next toggle is seen

            // Launch from queue with a fresh event in the same cycle: net zero
            if (launch && (|pend_q) && !evt_i)         pend_q <= pend_q - 1'b1;
            else if (evt_i && !launch && !(&pend_q))   pend_q <= pend_q + 1'b1;

            if (drop)           ovf_q <= 1'b1;
            else if (ovf_clr_i) ovf_q <= 1'b0;
        end
    end

`ifdef NAMURU_PSEND_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_q;

    // A real ack in the final cycle wins; the timeout only fires on mismatch
    assign tmo_hit = (state_q == PS_WAIT) && (ack_s != req_q) &&
                     (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clks or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (launch)                  tmo_cnt <= '0;
            else if (state_q == PS_WAIT) tmo_cnt <= tmo_cnt + 1'b1;

            if (tmo_hit)        tmo_q <= 1'b1;
            else if (ovf_clr_i) tmo_q <= 1'b0;
        end
    end

    assign tmo_o = tmo_q;
`else
    assign tmo_hit = 1'b0;
    assign tmo_o   = 1'b0;
`endif

    assign req_o  = req_q;
    assign pend_o = pend_q;
    assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_namuru_psend.sv
// tb_namuru_psend
//  Directed bench for namuru_psend. Instance A (PEND_W=4) has its ack driven
//  from a delayed copy of its own req; instance B (PEND_W=2, TIMEOUT_CYC=16)
//  has a held ack for the saturation and timeout scenarios.
module tb_namuru_psend;

    logic clks = 1'b0;
    logic rstn = 1'b0;
    always #5 clks = ~clks;

    logic       evt_a = 1'b0, clr_a = 1'b0, ack_a;
    logic       req_a, busy_a, ovf_a, tmo_a;
    logic [3:0] pend_a;

    logic       evt_b = 1'b0, clr_b = 1'b0, ack_b = 1'b0;
    logic       req_b, busy_b, ovf_b, tmo_b;
    logic [1:0] pend_b;

    // Loopback for A: ack_a = req_a delayed by dly_n clocks
    logic        loop_a = 1'b0, hold_a = 1'b0;
    int          dly_n = 3;
    logic [15:0] dly_q;
    always @(posedge clks or negedge rstn) begin
        if (!rstn) dly_q <= '0;
        else       dly_q <= {dly_q[14:0], req_a};
    end
    assign ack_a = loop_a ? dly_q[dly_n-1] : hold_a;

    namuru_psend #(.PEND_W(4)) dut_a (
        .clks(clks), .rstn(rstn), .evt_i(evt_a), .ack_i(ack_a), .ovf_clr_i(clr_a),
        .req_o(req_a), .busy_o(busy_a), .pend_o(pend_a), .ovf_o(ovf_a), .tmo_o(tmo_a)
    );

    namuru_psend #(.PEND_W(2), .TIMEOUT_CYC(16)) dut_b (
        .clks(clks), .rstn(rstn), .evt_i(evt_b), .ack_i(ack_b), .ovf_clr_i(clr_b),
        .req_o(req_b), .busy_o(busy_b), .pend_o(pend_b), .ovf_o(ovf_b), .tmo_o(tmo_b)
    );

    int checks   = 0;
    int failures = 0;
    int tog, maxp;
    logic prev_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clks);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        step();
    endtask

    task automatic track();
        if (req_a !== prev_req) tog++;
        prev_req = req_a;
        if (int'(pend_a) > maxp) maxp = int'(pend_a);
    endtask

    initial begin
        // ---- 1: reset state, single event with 3-cycle loopback ----
        do_reset();
        chk("rst_req",  req_a,  1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_pend", pend_a, 4'd0);
        chk("rst_ovf",  ovf_a,  1'b0);
        chk("rst_tmo",  tmo_a,  1'b0);
        chk("rst_req_b", req_b, 1'b0);
        loop_a = 1'b1; dly_n = 3;
        evt_a = 1'b1; step(); evt_a = 1'b0;          // E1
        chk("t1_req",  req_a,  1'b1);
        chk("t1_busy", busy_a, 1'b1);
        chk("t1_pend", pend_a, 4'd0);
        repeat (7) step();                           // E8: ack_s just arrived
        chk("t1_busy_hold", busy_a, 1'b1);
        step();                                      // E9: back to IDLE
        chk("t1_busy_done", busy_a, 1'b0);
        chk("t1_pend_end",  pend_a, 4'd0);
        chk("t1_req_end",   req_a,  1'b1);

        // ---- 2: five back-to-back events, 10-cycle loopback ----
        do_reset();
        loop_a = 1'b1; dly_n = 10;
        tog = 0; maxp = 0; prev_req = req_a;
        for (int i = 0; i < 5; i++) begin
            evt_a = 1'b1; step(); track();
        end
        evt_a = 1'b0;
        chk("t2_pend_peak", pend_a, 4'd4);
        for (int c = 0; c < 400 && !(tog == 5 && !busy_a && pend_a == 4'd0); c++) begin
            step(); track();
        end
        chk("t2_toggles", tog, 5);
        chk("t2_maxp",    maxp, 4);
        chk("t2_req_end", req_a, 1'b1);
        chk("t2_pend_end", pend_a, 4'd0);
        chk("t2_busy_end", busy_a, 1'b0);

        // ---- 3: saturation and overflow on PEND_W=2 ----
        do_reset();
        ack_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            evt_b = 1'b1; step(); evt_b = 1'b0;
        end
        chk("t3_pend_sat", pend_b, 2'd3);
        chk("t3_ovf_set",  ovf_b,  1'b1);
        chk("t3_busy",     busy_b, 1'b1);
        clr_b = 1'b1; step(); clr_b = 1'b0;
        chk("t3_ovf_clr",  ovf_b,  1'b0);
        chk("t3_pend_kept", pend_b, 2'd3);
        evt_b = 1'b1; clr_b = 1'b1; step(); evt_b = 1'b0; clr_b = 1'b0;
        chk("t3_ovf_prio", ovf_b,  1'b1);
        chk("t3_pend_sat2", pend_b, 2'd3);

        // ---- 4: async reset mid-handshake ----
        do_reset();
        loop_a = 1'b0; hold_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            evt_a = 1'b1; step();
        end
        evt_a = 1'b0;
        chk("t4_pend_pre", pend_a, 4'd2);
        chk("t4_busy_pre", busy_a, 1'b1);
        #2 rstn = 1'b0;
        #1;
        chk("t4_req_async",  req_a,  1'b0);
        chk("t4_busy_async", busy_a, 1'b0);
        chk("t4_pend_async", pend_a, 4'd0);
        chk("t4_ovf_async",  ovf_a,  1'b0);
        #2 rstn = 1'b1;
        step();
        loop_a = 1'b1; dly_n = 3;
        evt_a = 1'b1; step(); evt_a = 1'b0;
        chk("t4_relaunch_req",  req_a,  1'b1);
        chk("t4_relaunch_busy", busy_a, 1'b1);
        chk("t4_relaunch_pend", pend_a, 4'd0);

        // ---- 5: ack stuck at 0 after a launch ----
        do_reset();
        ack_b = 1'b0;
        evt_b = 1'b1; step(); evt_b = 1'b0;          // E1
        repeat (15) step();                          // E16
        chk("t5_busy_16", busy_b, 1'b1);
        chk("t5_tmo_16",  tmo_b,  1'b0);
        step();                                      // E17
`ifdef NAMURU_PSEND_TIMEOUT_EN
        chk("t5_tmo_set",  tmo_b,  1'b1);
        chk("t5_req_sync", req_b,  1'b0);
        chk("t5_busy_off", busy_b, 1'b0);
        clr_b = 1'b1; step(); clr_b = 1'b0;
        chk("t5_tmo_clr",  tmo_b,  1'b0);
`else
        chk("t5_tmo_zero", tmo_b,  1'b0);
        chk("t5_busy_on",  busy_b, 1'b1);
        chk("t5_req_held", req_b,  1'b1);
`endif

        // ---- 6: event on the WAIT->IDLE edge with one queued ----
        do_reset();
        loop_a = 1'b1; dly_n = 3;
        evt_a = 1'b1; step();                        // E1 launch
        step(); evt_a = 1'b0;                        // E2 queued
        chk("t6_pend_1", pend_a, 4'd1);
        repeat (6) step();                           // E8
        chk("t6_busy_e8", busy_a, 1'b1);
        evt_a = 1'b1; step(); evt_a = 1'b0;          // E9: leave WAIT, event queues
        chk("t6_pend_2",   pend_a, 4'd2);
        chk("t6_busy_e9",  busy_a, 1'b0);
        chk("t6_req_e9",   req_a,  1'b1);
        step();                                      // E10: launch from queue
        chk("t6_pend_e10", pend_a, 4'd1);
        chk("t6_busy_e10", busy_a, 1'b1);
        chk("t6_req_e10",  req_a,  1'b0);
        for (int c = 0; c < 200 && (busy_a || pend_a != 4'd0); c++) step();
        chk("t6_pend_end", pend_a, 4'd0);
        chk("t6_busy_end", busy_a, 1'b0);
        chk("t6_req_end",  req_a,  1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
